mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request strobe, sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV.
REQ-006 SHALL have port a  input  XLEN  multiplicand or dividend.
REQ-007 SHALL have port b  input  XLEN  multiplier or divisor.
REQ-008 SHALL have port busy  output  1  operation in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port hi  output  XLEN  product upper half or remainder.
REQ-011 SHALL have port lo  output  XLEN  product lower half or quotient.
REQ-012 SHALL have port div_by_zero  output  1  pulse with done when a divide had b == 0.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX; IDLE->CALC on start, CALC->FIX after exactly XLEN iterations, FIX->IDLE unconditionally.
REQ-014 SHALL latch op, a and b on the accepting edge; later changes to inputs SHALL NOT affect the result.
REQ-015 SHALL hold busy high from the edge after acceptance until the edge at which done rises.
REQ-016 SHALL make done high exactly XLEN+1 cycles after the accepting edge, for one cycle; hi/lo SHALL update on that same edge.
REQ-017 SHALL ignore start while busy; no queuing.
REQ-018 SHALL accept start in the cycle done is high, because the state is IDLE then.
REQ-019 SHALL compute multiply by radix-2 shift-add on magnitudes; the result SHALL be the full 2*XLEN-bit product {hi,lo}.
REQ-020 SHALL compute divide by restoring division on magnitudes, one quotient bit per CALC cycle.
REQ-021 SHALL, in FIX for signed ops, negate the product when the operand signs differ.
REQ-022 SHALL, in FIX for signed divides, truncate the quotient toward zero and give the remainder the dividend's sign.
REQ-023 SHALL, for a divide with b == 0, return lo = all ones and hi = a, with div_by_zero pulsed alongside done.
REQ-024 SHALL, for signed DIV of most-negative by -1, return lo = most-negative and hi = 0, with no flag.
REQ-025 SHALL hold hi/lo stable between completions.

Reset
REQ-026 SHALL, when rst is high at an edge, force IDLE with busy = 0, done = 0, div_by_zero = 0, hi = 0 and lo = 0.
REQ-027 SHALL abort an in-flight operation on reset, with no done pulse.
REQ-028 SHALL give rst priority over start on the same edge.

Configuration
REQ-029 SHALL, when macro MDU_SIGNED_EN is defined, support signed MULT/DIV per REQ-021, REQ-022 and REQ-024.
REQ-030 SHALL, without MDU_SIGNED_EN, execute op 1 as MULTU and op 3 as DIVU; sign-conditioning logic SHALL be absent.

Structure
REQ-031 SHALL take the op encoding enum and state enum from shared package mdu_pkg, which other blocks also use for op decode.
REQ-032 SHALL place the iteration datapath (accumulator, shift registers, add/subtract) in one sub-module, mdu_iter_core; FSM, sign handling and output registers SHALL remain in mult_div_unit.

Verification (XLEN = 32)
REQ-033 SHALL cover: MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; done exactly 33 cycles after accept.
REQ-034 SHALL cover: MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 SHALL cover: DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-036 SHALL cover: DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1 for one cycle with done.
REQ-037 SHALL cover: MULT 2x3, with a second start of 4x4 issued mid-busy -> the second start is ignored, result is lo=6; a third start in the done cycle is accepted.
REQ-038 SHALL cover: rst at iteration 10 of DIV -> next cycle busy=0, hi=lo=0, and no done pulse.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encoding,
// controller state encoding and small op-decode helpers used by other blocks.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'd0,
        OP_MULT  = 2'd1,
        OP_DIVU  = 2'd2,
        OP_DIV   = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    // True for the two divide encodings.
    function automatic logic op_is_div(input mdu_op_e op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    // True for the two signed encodings.
    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iteration datapath of the multiply/divide unit. Works on operand
// magnitudes only: radix-2 shift-add multiply or restoring divide, one bit
// per step. acc_r holds the product upper half / partial remainder, mq_r
// holds the multiplier / dividend being shifted out while the product lower
// half / quotient is shifted in.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] hi_res,
    output logic [XLEN-1:0] lo_res
);

    logic [XLEN:0]   acc_r;
    logic [XLEN-1:0] mq_r;
    logic [XLEN-1:0] opnd_r;
    logic            div_mode_r;

    logic [XLEN:0]   mul_sum_s;
    logic [XLEN:0]   div_shift_s;
    logic [XLEN:0]   div_diff_s;
    logic [XLEN:0]   acc_nxt_s;
    logic [XLEN-1:0] mq_nxt_s;

    // Next-state of one iteration for either multiply or divide.
    always_comb begin
        mul_sum_s   = {1'b0, opnd_r};
        div_shift_s = {acc_r[XLEN-1:0], mq_r[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        acc_nxt_s   = acc_r;
        mq_nxt_s    = mq_r;
        if (mq_r[0]) begin
            mul_sum_s = acc_r + {1'b0, opnd_r};
        end else begin
            mul_sum_s = acc_r;
        end
        if (div_mode_r) begin
            // Restoring step: keep the difference only when it is non-negative.
            if (!div_diff_s[XLEN]) begin
                acc_nxt_s = div_diff_s;
                mq_nxt_s  = {mq_r[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt_s = div_shift_s;
                mq_nxt_s  = {mq_r[XLEN-2:0], 1'b0};
            end
        end else begin
            // Shift the conditional sum right across acc/mq.
            acc_nxt_s = {1'b0, mul_sum_s[XLEN:1]};
            mq_nxt_s  = {mul_sum_s[0], mq_r[XLEN-1:1]};
        end
    end

    // Datapath registers: load operands on accept, iterate while stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r      <= {(XLEN+1){1'b0}};
            mq_r       <= {XLEN{1'b0}};
            opnd_r     <= {XLEN{1'b0}};
            div_mode_r <= 1'b0;
        end else if (load) begin
            acc_r      <= {(XLEN+1){1'b0}};
            mq_r       <= a_mag;
            opnd_r     <= b_mag;
            div_mode_r <= is_div;
        end else if (step) begin
            acc_r      <= acc_nxt_s;
            mq_r       <= mq_nxt_s;
        end else begin
            acc_r      <= acc_r;
            mq_r       <= mq_r;
        end
    end

    assign hi_res = acc_r[XLEN-1:0];
    assign lo_res = mq_r;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: IDLE -> CALC (XLEN iterations) -> FIX.
// Result appears with a one-cycle done pulse XLEN+1 cycles after accept.
// Build option: define MDU_SIGNED_EN to enable signed MULT/DIV; without it
// ops 1 and 3 run as MULTU and DIVU.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div_by_zero
);

    localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    mdu_state_e      state_r;
    logic [CW-1:0]   cnt_r;
    logic            div_r;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;

    mdu_op_e         op_s;
    logic            accept_s;
    logic [XLEN-1:0] a_mag_s;
    logic [XLEN-1:0] b_mag_s;
    logic [XLEN-1:0] core_hi_s;
    logic [XLEN-1:0] core_lo_s;
    logic [XLEN-1:0] fix_hi_s;
    logic [XLEN-1:0] fix_lo_s;
    logic            fix_dbz_s;

    assign op_s     = mdu_op_e'(op);
    assign accept_s = (state_r == IDLE) && start;

`ifdef MDU_SIGNED_EN
    logic neg_a_r;
    logic neg_b_r;
    logic neg_a_s;
    logic neg_b_s;

    // Operand sign capture and magnitude conversion for signed ops.
    always_comb begin
        neg_a_s = op_is_signed(op_s) & a[XLEN-1];
        neg_b_s = op_is_signed(op_s) & b[XLEN-1];
        if (neg_a_s) begin
            a_mag_s = -a;
        end else begin
            a_mag_s = a;
        end
        if (neg_b_s) begin
            b_mag_s = -b;
        end else begin
            b_mag_s = b;
        end
    end
`else
    assign a_mag_s = a;
    assign b_mag_s = b;
`endif

    mdu_iter_core #(.XLEN(XLEN)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (accept_s),
        .step   (state_r == CALC),
        .is_div (op_is_div(op_s)),
        .a_mag  (a_mag_s),
        .b_mag  (b_mag_s),
        .hi_res (core_hi_s),
        .lo_res (core_lo_s)
    );

    // Final result conditioning applied in FIX: divide-by-zero and signs.
    always_comb begin
        fix_dbz_s = div_r && (b_r == {XLEN{1'b0}});
        fix_hi_s  = core_hi_s;
        fix_lo_s  = core_lo_s;
        if (fix_dbz_s) begin
            fix_hi_s = a_r;
            fix_lo_s = {XLEN{1'b1}};
        end else if (div_r) begin
`ifdef MDU_SIGNED_EN
            // Quotient truncates toward zero; remainder follows the dividend.
            if (neg_a_r ^ neg_b_r) begin
                fix_lo_s = -core_lo_s;
            end else begin
                fix_lo_s = core_lo_s;
            end
            if (neg_a_r) begin
                fix_hi_s = -core_hi_s;
            end else begin
                fix_hi_s = core_hi_s;
            end
`else
            fix_hi_s = core_hi_s;
            fix_lo_s = core_lo_s;
`endif
        end else begin
`ifdef MDU_SIGNED_EN
            if (neg_a_r ^ neg_b_r) begin
                {fix_hi_s, fix_lo_s} = -{core_hi_s, core_lo_s};
            end else begin
                {fix_hi_s, fix_lo_s} = {core_hi_s, core_lo_s};
            end
`else
            fix_hi_s = core_hi_s;
            fix_lo_s = core_lo_s;
`endif
        end
    end

    // Controller FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            div_r       <= 1'b0;
            a_r         <= {XLEN{1'b0}};
            b_r         <= {XLEN{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= {XLEN{1'b0}};
            lo          <= {XLEN{1'b0}};
`ifdef MDU_SIGNED_EN
            neg_a_r     <= 1'b0;
            neg_b_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                    if (start) begin
                        div_r   <= op_is_div(op_s);
                        a_r     <= a;
                        b_r     <= b;
                        cnt_r   <= {CW{1'b0}};
                        busy    <= 1'b1;
                        state_r <= CALC;
`ifdef MDU_SIGNED_EN
                        neg_a_r <= neg_a_s;
                        neg_b_r <= neg_b_s;
`endif
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                CALC: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST_ITER) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FIX: begin
                    hi          <= fix_hi_s;
                    lo          <= fix_lo_s;
                    div_by_zero <= fix_dbz_s;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                end
            endcase
        end
    end

endmodule
